// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the Wishbone RAM responder.
// Holds the FSM state enum, bus width defaults and the miss read value.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam int         WB_DATA_WIDTH = 8;
  localparam int         WB_ADDR_WIDTH = 16;
  localparam logic [7:0] OOR_READ_DATA = 8'hFF;
  localparam int         WB_CNT_W      = 4;

endpackage

// File: rtl/wb_ram_array.sv
// wb_ram_array: synchronous single-port RAM with a registered read port.
// Contents are never reset; the read register only updates on re_i.
module wb_ram_array #(
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rdata;

  // write port and registered read share one address
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone slave fronting an on-chip RAM window.
// Define WB_RESP_ERR_EN to add err_o and report window misses on it.
module wb_ram_responder
  import wb_pkg::*;
#(
  parameter int                    DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int                    MEM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WAIT_STATES    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
`ifdef WB_RESP_ERR_EN
  output logic                  err_o,
`endif
  output logic [DATA_WIDTH-1:0] dat_o
);

  localparam int HI_W = ADDR_WIDTH - MEM_ADDR_WIDTH;
  localparam logic [HI_W-1:0] LP_BASE_HI =
    BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  localparam logic [WB_CNT_W-1:0] LP_CNT_LOAD =
    (WAIT_STATES > 0) ? WB_CNT_W'(WAIT_STATES - 1) : '0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WB_CNT_W-1:0] r_cnt;
  logic [WB_CNT_W-1:0] w_cnt_nxt;
  logic                r_we;
  logic                r_hit;
  logic                w_cap;
  logic                w_hit;
  logic                w_in_ack;
  logic [DATA_WIDTH-1:0] w_rdata;

  // stb_i is only looked at outside WAIT
  assign w_cap = stb_i && (r_state != WAIT);
  assign w_hit = (adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == LP_BASE_HI);

  wb_ram_array #(
    .WIDTH (DATA_WIDTH),
    .AW    (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_cap && w_hit && we_i),
    .re_i    (w_cap && w_hit && !we_i),
    .addr_i  (adr_i[MEM_ADDR_WIDTH-1:0]),
    .wdata_i (dat_i),
    .rdata_o (w_rdata)
  );

  // state, wait counter and the captured request attributes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_we  <= we_i;
        r_hit <= w_hit;
      end
    end
  end

  // next state: capture from IDLE/ACK, count down in WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = ACK;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        if (stb_i) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ACK;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign w_in_ack = (r_state == ACK);

`ifdef WB_RESP_ERR_EN
  assign ack_o = w_in_ack && r_hit;
  assign err_o = w_in_ack && !r_hit;
  assign dat_o = (w_in_ack && r_hit && !r_we) ? w_rdata : '0;
`else
  assign ack_o = w_in_ack;
  assign dat_o = (!w_in_ack || r_we) ? '0 :
                 r_hit ? w_rdata : DATA_WIDTH'(OOR_READ_DATA);
`endif

endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed bench for wb_ram_responder.
// Two instances: WAIT_STATES=0 (u0) and WAIT_STATES=3 (u3).
module tb_wb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb0, we0, stb3, we3;
  logic [15:0] adr0, adr3;
  logic [7:0]  din0, din3;
  logic        ack0, ack3;
  logic [7:0]  dat0, dat3;
`ifdef WB_RESP_ERR_EN
  logic        err0, err3;
`endif
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  n_ack;

  always #5 clk = ~clk;

  wb_ram_responder #(
    .MEM_ADDR_WIDTH (10),
    .BASE_ADDR      (16'h0000),
    .WAIT_STATES    (0)
  ) u0 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .stb_i   (stb0),
    .we_i    (we0),
    .adr_i   (adr0),
    .dat_i   (din0),
    .ack_o   (ack0),
`ifdef WB_RESP_ERR_EN
    .err_o   (err0),
`endif
    .dat_o   (dat0)
  );

  wb_ram_responder #(
    .MEM_ADDR_WIDTH (10),
    .BASE_ADDR      (16'h0000),
    .WAIT_STATES    (3)
  ) u3 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .stb_i   (stb3),
    .we_i    (we3),
    .adr_i   (adr3),
    .dat_i   (din3),
    .ack_o   (ack3),
`ifdef WB_RESP_ERR_EN
    .err_o   (err3),
`endif
    .dat_o   (dat3)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic t3(input logic w, input logic [15:0] a,
                    input logic [7:0] d, input logic [7:0] x,
                    input string tag);
    stb3 = 1'b1; we3 = w; adr3 = a; din3 = d;
    tick();
    stb3 = 1'b0;
    chk1({tag, "_w0"}, ack3, 1'b0);
    tick();
    chk1({tag, "_w1"}, ack3, 1'b0);
    tick();
    chk1({tag, "_w2"}, ack3, 1'b0);
    tick();
    chk1({tag, "_ack"}, ack3, 1'b1);
    if (!w) chk8({tag, "_dat"}, dat3, x);
  endtask

  initial begin
    rst_n = 1'b0;
    stb0 = 1'b0; we0 = 1'b0; adr0 = '0; din0 = '0;
    stb3 = 1'b0; we3 = 1'b0; adr3 = '0; din3 = '0;
    n_ack = '0;

    repeat (10) @(posedge clk);
    #1;
    chk1("rst_ack0", ack0, 1'b0);
    chk8("rst_dat0", dat0, 8'h00);
    chk1("rst_ack3", ack3, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk1("post_rst_ack0", ack0, 1'b0);
    chk8("post_rst_dat0", dat0, 8'h00);
    chk8("post_rst_dat3", dat3, 8'h00);
`ifdef WB_RESP_ERR_EN
    chk1("post_rst_err0", err0, 1'b0);
`endif

    stb0 = 1'b1; we0 = 1'b1; adr0 = 16'h0010; din0 = 8'hA5;
    tick();
    chk1("b2b_wr_ack", ack0, 1'b1);
    we0 = 1'b0;
    tick();
    chk1("b2b_rd_ack", ack0, 1'b1);
    chk8("b2b_rd_dat", dat0, 8'hA5);
    we0 = 1'b1; adr0 = 16'h0000; din0 = 8'h5A;
    tick();
    chk1("wr0_ack", ack0, 1'b1);
    we0 = 1'b0; adr0 = 16'h0400;
    tick();
`ifdef WB_RESP_ERR_EN
    chk1("miss_rd_ack", ack0, 1'b0);
    chk1("miss_rd_err", err0, 1'b1);
    chk8("miss_rd_dat", dat0, 8'h00);
`else
    chk1("miss_rd_ack", ack0, 1'b1);
    chk8("miss_rd_dat", dat0, 8'hFF);
`endif
    we0 = 1'b1; adr0 = 16'h0400; din0 = 8'h77;
    tick();
`ifdef WB_RESP_ERR_EN
    chk1("miss_wr_ack", ack0, 1'b0);
    chk1("miss_wr_err", err0, 1'b1);
`else
    chk1("miss_wr_ack", ack0, 1'b1);
`endif
    we0 = 1'b0; adr0 = 16'h0000;
    tick();
    chk1("ram0_ack", ack0, 1'b1);
    chk8("ram0_kept", dat0, 8'h5A);
`ifdef WB_RESP_ERR_EN
    chk1("hit_no_err", err0, 1'b0);
`endif
    stb0 = 1'b0;
    tick();
    chk1("idle_ack0", ack0, 1'b0);
    chk8("idle_dat0", dat0, 8'h00);

    t3(1'b1, 16'h0020, 8'h3C, 8'h00, "pre");
    tick();
    chk1("ack_one_cycle", ack3, 1'b0);
    chk8("ack_drop_dat", dat3, 8'h00);

    stb3 = 1'b1; we3 = 1'b0; adr3 = 16'h0020;
    tick();
    chk1("rd_e0", ack3, 1'b0);
    we3 = 1'b1; din3 = 8'hEE;
    tick();
    chk1("rd_e1_ign", ack3, 1'b0);
    stb3 = 1'b0;
    tick();
    chk1("rd_e2", ack3, 1'b0);
    tick();
    chk1("rd_e3_ack", ack3, 1'b1);
    chk8("rd_e3_dat", dat3, 8'h3C);

    stb3 = 1'b1; we3 = 1'b1; adr3 = 16'h0005; din3 = 8'h11;
    tick();
    chk1("rs_e0", ack3, 1'b0);
    stb3 = 1'b0;
    tick();
    chk1("rs_e1", ack3, 1'b0);
    tick();
    chk1("rs_e2", ack3, 1'b0);
    tick();
    chk1("rs_ack", ack3, 1'b1);
    tick();
    chk1("rs_no_extra", ack3, 1'b0);

    t3(1'b0, 16'h0020, 8'h00, 8'h3C, "ign_not_written");
    tick();
    t3(1'b0, 16'h0005, 8'h00, 8'h11, "rs_data");
    tick();

    stb3 = 1'b1; we3 = 1'b0; adr3 = 16'h0020;
    tick();
    stb3 = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_in_rst", ack3, 1'b0);
    repeat (4) begin
      tick();
      if (ack3) n_ack = n_ack + 8'd1;
    end
    #2 rst_n = 1'b1;
    repeat (6) begin
      tick();
      if (ack3) n_ack = n_ack + 8'd1;
    end
    chk8("abort_no_ack", n_ack, 8'd0);

    t3(1'b0, 16'h0020, 8'h00, 8'h3C, "ram_kept_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
